// File: rtl/multibank_fifo_arb.sv
// multibank_fifo_arb: round-robin multi-master front end over NUM_B FIFO banks.
// Writes rotate across banks; reads pop the bank the granted master names.
// Optional build macro MBF_SKIP_FULL_EN: writes skip past full banks instead
// of being dropped at a full rotation target.

module mbf_bank #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;

  // storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // pointers wrap naturally (DEPTH is a power of 2); push+pop keeps cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module multibank_fifo_arb #(
  parameter int NUM_M = 2,
  parameter int NUM_B = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int BW    = $clog2(NUM_B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    wr_en,
  input  logic [NUM_M*DW-1:0] wr_data,
  input  logic [NUM_M-1:0]    rd_en,
  input  logic [NUM_M*BW-1:0] rd_id,
  output logic [NUM_M-1:0]    grant,
  output logic [DW-1:0]       rd_data,
  output logic [NUM_M-1:0]    rd_valid,
  output logic [NUM_M-1:0]    wr_drop,
  output logic [NUM_M-1:0]    rd_err,
  output logic [NUM_B-1:0]    bank_full,
  output logic [NUM_B-1:0]    bank_empty
);
  localparam int MW = $clog2(NUM_M);

  logic [MW-1:0]              rr_ptr, gnt_idx;
  logic                       gnt_any;
  logic [NUM_M-1:0]           req;
  logic [BW-1:0]              wr_bank, wr_tgt, rd_tgt;
  logic                       wr_ok, do_wr, do_rd, wr_dropped, rd_failed;
  logic [DW-1:0]              gnt_wdata;
  logic [NUM_B-1:0]           push, pop;
  logic [NUM_B-1:0][DW-1:0]   head;

  assign req = wr_en | rd_en;

  // round-robin pick: first requester found cyclically from rr_ptr
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int o = 0; o < NUM_M; o++) begin
      if (!gnt_any && req[(int'(rr_ptr) + o) % NUM_M]) begin
        gnt_any = 1'b1;
        gnt_idx = MW'((int'(rr_ptr) + o) % NUM_M);
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

`ifdef MBF_SKIP_FULL_EN
  // write target: first non-full bank searching cyclically from wr_bank
  always_comb begin
    wr_tgt = wr_bank;
    wr_ok  = 1'b0;
    for (int o = 0; o < NUM_B; o++) begin
      if (!wr_ok && !bank_full[BW'(int'(wr_bank) + o)]) begin
        wr_ok  = 1'b1;
        wr_tgt = BW'(int'(wr_bank) + o);
      end
    end
  end
`else
  // strict rotation: a full target bank means the write is dropped
  assign wr_tgt = wr_bank;
  assign wr_ok  = !bank_full[wr_bank];
`endif

  // full/empty come from registered state, so same-cycle push/pop never
  // rescues a full write or lets a read fall through an empty bank
  assign gnt_wdata  = wr_data[gnt_idx*DW +: DW];
  assign rd_tgt     = rd_id[gnt_idx*BW +: BW];
  assign do_wr      = gnt_any & wr_en[gnt_idx] & wr_ok;
  assign wr_dropped = gnt_any & wr_en[gnt_idx] & ~wr_ok;
  assign do_rd      = gnt_any & rd_en[gnt_idx] & ~bank_empty[rd_tgt];
  assign rd_failed  = gnt_any & rd_en[gnt_idx] & bank_empty[rd_tgt];

  for (genvar b = 0; b < NUM_B; b++) begin : g_bank
    assign push[b] = do_wr && (wr_tgt == BW'(b));
    assign pop[b]  = do_rd && (rd_tgt == BW'(b));
    mbf_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .push  (push[b]),
      .pop   (pop[b]),
      .wdata (gnt_wdata),
      .head  (head[b]),
      .full  (bank_full[b]),
      .empty (bank_empty[b])
    );
  end

  // arbitration pointer, write rotation and one-cycle response pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      wr_bank  <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      wr_drop  <= '0;
      rd_err   <= '0;
    end else begin
      if (gnt_any) rr_ptr <= (gnt_idx == MW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
      if (do_wr)   wr_bank <= wr_tgt + 1'b1;
      if (do_rd)   rd_data <= head[rd_tgt];
      rd_valid <= do_rd      ? grant : '0;
      wr_drop  <= wr_dropped ? grant : '0;
      rd_err   <= rd_failed  ? grant : '0;
    end
  end
endmodule

// File: tb/tb_multibank_fifo_arb.sv
// Directed self-checking bench for multibank_fifo_arb (default parameters).
module tb_multibank_fifo_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_en = '0, rd_en = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_id = '0;
  logic [1:0]  grant, rd_valid, wr_drop, rd_err;
  logic [7:0]  rd_data;
  logic [3:0]  bank_full, bank_empty;

  int checks = 0;
  int errors = 0;

  multibank_fifo_arb #(.NUM_M(2), .NUM_B(4), .DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_id(rd_id), .grant(grant), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_drop(wr_drop), .rd_err(rd_err), .bank_full(bank_full),
    .bank_empty(bank_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en = '0; rd_en = '0; wr_data = '0; rd_id = '0;
  endtask

  task automatic set_m(input int m, input bit we, input logic [7:0] d,
                       input bit re, input logic [1:0] id);
    wr_en[m] = we; wr_data[m*8 +: 8] = d; rd_en[m] = re; rd_id[m*2 +: 2] = id;
  endtask

  task automatic apply_reset;
    idle; rst = 1'b1; tick; tick; rst = 1'b0; tick;
  endtask

  task automatic fill16;
    for (int i = 0; i < 16; i++) begin
      idle; set_m(0, 1, 8'(i), 0, 0); tick;
    end
    idle;
  endtask

  task automatic test_reset;
    idle; rst = 1'b1; tick; tick;
    checks++; if (bank_empty !== 4'hF) begin errors++; $display("FAIL reset_empty got=%h exp=f", bank_empty); end
    checks++; if (bank_full !== 4'h0) begin errors++; $display("FAIL reset_full got=%h exp=0", bank_full); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if ({rd_valid, wr_drop, rd_err} !== 6'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=000000", {rd_valid, wr_drop, rd_err}); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    rst = 1'b0; tick;
  endtask

  task automatic test_empty_read;
    apply_reset;
    set_m(0, 0, 8'h00, 1, 2'd3); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL eread_grant got=%b exp=01", grant); end
    tick;
    checks++; if (rd_err !== 2'b01) begin errors++; $display("FAIL eread_err got=%b exp=01", rd_err); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL eread_valid got=%b exp=00", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL eread_data got=%h exp=00", rd_data); end
    idle; tick;
    checks++; if (rd_err !== 2'b00) begin errors++; $display("FAIL eread_pulse got=%b exp=00", rd_err); end
  endtask

  task automatic test_same_cycle_empty;
    apply_reset;
    set_m(0, 1, 8'h5A, 1, 2'd0); tick;
    checks++; if (rd_err !== 2'b01) begin errors++; $display("FAIL nofall_err got=%b exp=01", rd_err); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL nofall_valid got=%b exp=00", rd_valid); end
    checks++; if (bank_empty !== 4'b1110) begin errors++; $display("FAIL nofall_empty got=%b exp=1110", bank_empty); end
    idle; set_m(0, 0, 8'h00, 1, 2'd0); tick;
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h5A) begin errors++; $display("FAIL nofall_pop got=%b/%h exp=01/5a", rd_valid, rd_data); end
    idle;
  endtask

  task automatic test_rr_and_read;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] ids   [3] = '{2'd0, 2'd1, 2'd3};
    logic [7:0] exp_d [3] = '{8'h10, 8'h20, 8'h21};
    logic [7:0] d0 = 8'h10, d1 = 8'h20;
    logic [1:0] g;
    apply_reset;
    for (int c = 0; c < 4; c++) begin
      set_m(0, 1, d0, 0, 0); set_m(1, 1, d1, 0, 0); #1;
      g = grant;
      checks++; if (g !== exp_g[c]) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, g, exp_g[c]); end
      tick;
      checks++; if (rd_valid !== 2'b00 || wr_drop !== 2'b00) begin errors++; $display("FAIL rr_pulses c=%0d got=%b/%b exp=00/00", c, rd_valid, wr_drop); end
      if (g[0]) d0++; else d1++;
    end
    checks++; if (bank_empty !== 4'h0) begin errors++; $display("FAIL rr_empty got=%b exp=0000", bank_empty); end
    idle; set_m(1, 0, 8'h00, 1, 2'd2); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL read_grant got=%b exp=10", grant); end
    tick;
    checks++; if (rd_valid !== 2'b10) begin errors++; $display("FAIL read_valid got=%b exp=10", rd_valid); end
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL read_data got=%h exp=11", rd_data); end
    checks++; if (bank_empty !== 4'b0100) begin errors++; $display("FAIL read_empty got=%b exp=0100", bank_empty); end
    for (int i = 0; i < 3; i++) begin
      idle; set_m(0, 0, 8'h00, 1, ids[i]); tick;
      checks++; if (rd_valid !== 2'b01 || rd_data !== exp_d[i]) begin errors++; $display("FAIL read_bank%0d got=%b/%h exp=01/%h", ids[i], rd_valid, rd_data, exp_d[i]); end
    end
    idle;
    checks++; if (bank_empty !== 4'hF) begin errors++; $display("FAIL read_drained got=%b exp=1111", bank_empty); end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    set_m(0, 1, 8'h77, 0, 0); tick;
    set_m(0, 1, 8'h78, 1, 2'd0); tick;
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h77) begin errors++; $display("FAIL mid_pre got=%b/%h exp=01/77", rd_valid, rd_data); end
    #2 rst = 1'b1; #1;
    checks++; if (bank_empty !== 4'hF || bank_full !== 4'h0) begin errors++; $display("FAIL mid_flags got=%b/%b exp=1111/0000", bank_empty, bank_full); end
    checks++; if (rd_data !== 8'h00 || {rd_valid, wr_drop, rd_err} !== 6'b0) begin errors++; $display("FAIL mid_regs got=%h/%b exp=00/000000", rd_data, {rd_valid, wr_drop, rd_err}); end
    tick; tick; idle; rst = 1'b0; tick;
    checks++; if (bank_empty !== 4'hF || rd_data !== 8'h00 || {rd_valid, wr_drop, rd_err} !== 6'b0) begin errors++; $display("FAIL mid_post got=%b/%h/%b exp=1111/00/000000", bank_empty, rd_data, {rd_valid, wr_drop, rd_err}); end
  endtask

  task automatic test_full;
`ifdef MBF_SKIP_FULL_EN
    logic [7:0] exp_d [4] = '{8'h09, 8'h0D, 8'hAA, 8'h00};
    int n = 3;
`else
    logic [7:0] exp_d [4] = '{8'h05, 8'h09, 8'h0D, 8'h00};
    int n = 3;
`endif
    apply_reset;
    fill16;
    checks++; if (bank_full !== 4'hF) begin errors++; $display("FAIL full_flags got=%b exp=1111", bank_full); end
    checks++; if (wr_drop !== 2'b00) begin errors++; $display("FAIL full_nodrop got=%b exp=00", wr_drop); end
    set_m(0, 0, 8'h00, 1, 2'd1); tick;
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h01) begin errors++; $display("FAIL full_pop1 got=%b/%h exp=01/01", rd_valid, rd_data); end
    checks++; if (bank_full !== 4'b1101) begin errors++; $display("FAIL full_after_pop got=%b exp=1101", bank_full); end
    idle; set_m(0, 1, 8'hAA, 0, 0); tick;
`ifdef MBF_SKIP_FULL_EN
    checks++; if (wr_drop !== 2'b00) begin errors++; $display("FAIL skip_nodrop got=%b exp=00", wr_drop); end
    checks++; if (bank_full !== 4'hF) begin errors++; $display("FAIL skip_full got=%b exp=1111", bank_full); end
    // wr_bank is now 2: free banks 2 and 1, then a write must land in bank 2
    idle; set_m(0, 0, 8'h00, 1, 2'd2); tick;
    checks++; if (rd_data !== 8'h02) begin errors++; $display("FAIL skip_pop2 got=%h exp=02", rd_data); end
    idle; set_m(0, 0, 8'h00, 1, 2'd1); tick;
    checks++; if (rd_data !== 8'h05) begin errors++; $display("FAIL skip_pop1 got=%h exp=05", rd_data); end
    idle; set_m(0, 1, 8'hBB, 0, 0); tick;
    checks++; if (bank_full !== 4'b1101) begin errors++; $display("FAIL skip_wrbank got=%b exp=1101", bank_full); end
`else
    checks++; if (wr_drop !== 2'b01) begin errors++; $display("FAIL drop_pulse got=%b exp=01", wr_drop); end
    checks++; if (bank_full !== 4'b1101) begin errors++; $display("FAIL drop_full got=%b exp=1101", bank_full); end
`endif
    for (int i = 0; i < n; i++) begin
      idle; set_m(0, 0, 8'h00, 1, 2'd1); tick;
      checks++; if (rd_valid !== 2'b01 || rd_data !== exp_d[i]) begin errors++; $display("FAIL full_drain%0d got=%b/%h exp=01/%h", i, rd_valid, rd_data, exp_d[i]); end
    end
    idle; set_m(0, 0, 8'h00, 1, 2'd1); tick;
    checks++; if (rd_err !== 2'b01 || rd_data !== exp_d[n-1]) begin errors++; $display("FAIL full_hold got=%b/%h exp=01/%h", rd_err, rd_data, exp_d[n-1]); end
    idle;
  endtask

  task automatic test_full_same_cycle;
    apply_reset;
    fill16;
    set_m(0, 1, 8'h55, 1, 2'd0); tick;
    checks++; if (wr_drop !== 2'b01) begin errors++; $display("FAIL fsc_drop got=%b exp=01", wr_drop); end
    checks++; if (rd_valid !== 2'b01 || rd_data !== 8'h00) begin errors++; $display("FAIL fsc_pop got=%b/%h exp=01/00", rd_valid, rd_data); end
    checks++; if (bank_full !== 4'b1110) begin errors++; $display("FAIL fsc_full got=%b exp=1110", bank_full); end
    idle;
  endtask

  task automatic test_wrap;
    apply_reset;
    for (int c = 0; c < 8; c++) begin
      idle; set_m(0, 1, 8'(8'h30 + c), 0, 0); tick;
    end
    for (int c = 8; c < 24; c++) begin
      idle; set_m(0, 1, 8'(8'h30 + c), 1, 2'(c % 4)); tick;
      checks++; if (rd_valid !== 2'b01 || rd_data !== 8'(8'h30 + c - 8)) begin errors++; $display("FAIL wrap_pop c=%0d got=%b/%h exp=01/%h", c, rd_valid, rd_data, 8'(8'h30 + c - 8)); end
      checks++; if (bank_empty !== 4'h0 || bank_full !== 4'h0 || wr_drop !== 2'b00) begin errors++; $display("FAIL wrap_cnt c=%0d got=%b/%b/%b exp=0000/0000/00", c, bank_empty, bank_full, wr_drop); end
    end
    idle; set_m(0, 0, 8'h00, 1, 2'd0); tick;
    checks++; if (rd_data !== 8'h40) begin errors++; $display("FAIL wrap_tail0 got=%h exp=40", rd_data); end
    idle; set_m(0, 0, 8'h00, 1, 2'd0); tick;
    checks++; if (rd_data !== 8'h44) begin errors++; $display("FAIL wrap_tail1 got=%h exp=44", rd_data); end
    idle;
    checks++; if (bank_empty !== 4'b0001) begin errors++; $display("FAIL wrap_empty got=%b exp=0001", bank_empty); end
  endtask

  initial begin
    test_reset;
    test_empty_read;
    test_same_cycle_empty;
    test_rr_and_read;
    test_reset_mid;
    test_full;
    test_full_same_cycle;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multibank_fifo_arb.md
Name: multibank_fifo_arb

Overview:
Parametrised multi-master, multi-bank FIFO subsystem. It succeeds the fixed 2-master / 4-bank / 8-bit / fixed-depth bank FIFO. It is generalised in master count, bank count, data width and bank depth, and adds drop/error reporting and optional full-bank skipping. A round-robin master arbiter grants one master per cycle. Writes are distributed across internal banks in rotation; reads pop a master-selected bank.

Parameters:
NUM_M, 2, number of masters (>=2)
NUM_B, 4, number of banks (power of 2, >=2)
DW, 8, data width in bits
DEPTH, 4, entries per bank (power of 2, >=2)
BW, $clog2(NUM_B), bank-id width (derived; not to be overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
wr_en  in  NUM_M  per-master write request
wr_data  in  NUM_M*DW  per-master write data; master i occupies bits [i*DW +: DW]
rd_en  in  NUM_M  per-master read request
rd_id  in  NUM_M*BW  per-master target bank for reads
grant  out  NUM_M  one-hot combinational grant for the current cycle
rd_data  out  DW  registered data from the last successful pop (shared by all masters)
rd_valid  out  NUM_M  registered; one-cycle pulse to the master whose read succeeded
wr_drop  out  NUM_M  registered; one-cycle pulse when a granted write was discarded
rd_err  out  NUM_M  registered; one-cycle pulse when a granted read targeted an empty bank
bank_full  out  NUM_B  per-bank full flag (count==DEPTH), from registered state
bank_empty  out  NUM_B  per-bank empty flag (count==0), from registered state

Behaviour:
- Reset values:
  - rr_ptr=0, wr_bank=0.
  - All bank counts and pointers = 0.
  - rd_data=0; rd_valid, wr_drop and rd_err = 0.
  - bank_empty all 1s; bank_full all 0s.
  - Bank storage contents are not cleared.
  - Reset asserted mid-operation aborts everything immediately; no partial write or pop survives.
- Arbitration:
  - req[i] = wr_en[i] | rd_en[i].
  - Grant goes to the first requesting master found searching cyclically from rr_ptr.
  - On a grant to master k, rr_ptr <= (k+1) mod NUM_M. With no requests, rr_ptr holds.
  - Ungranted requests are ignored and not queued; the master must hold its request and retry.
  - A granted master with both wr_en and rd_en performs both operations in the same cycle.
- Write:
  - The granted write targets bank wr_bank.
  - If that bank is not full: data is stored at its write pointer, the pointer wraps mod DEPTH, and wr_bank <= (wr_bank+1) mod NUM_B.
  - If that bank is full: the write is discarded, wr_drop[k]=1 on the next cycle, and wr_bank holds.
- Read:
  - A granted read pops bank rd_id[k] if that bank is not empty.
  - Next cycle: rd_data = popped head, rd_valid[k]=1.
  - If the bank is empty: no pop, rd_err[k]=1 next cycle, rd_valid stays 0, rd_data holds.
- Latency: one cycle from granted request to rd_valid, wr_drop or rd_err. A pushed word is poppable one cycle after it is written.
- Same-cycle write and read on the same bank:
  - Full and empty are evaluated on pre-cycle state.
  - Write to a full bank is dropped even if that bank pops in the same cycle.
  - Read of an empty bank errors even if that bank is written in the same cycle (no fall-through).
  - Otherwise the count stays unchanged and both pointers advance.
- rd_data is held between successful reads.
- Bank count width is $clog2(DEPTH)+1 so that count can reach DEPTH.

Optional Feature:
Macro MBF_SKIP_FULL_EN.
- Defined: the write targets the first non-full bank searching cyclically from wr_bank, and wr_bank <= (chosen+1) mod NUM_B. wr_drop pulses only when all banks are full.
- Undefined: strict rotation; a write to a full target bank is dropped as described in Behaviour.

Test Plan:
- Reset check: assert rst mid-traffic -> bank_empty=4'hF, bank_full=0, rd_data=0, rd_valid/wr_drop/rd_err=0 immediately and after release.
- Round-robin writes: M0 writes 0x10..0x11 and M1 writes 0x20..0x21, both requesting 4 cycles -> grant=01,10,01,10; bank0..3 hold 0x10,0x20,0x11,0x21; rd_valid stays 0.
- Read: after the round-robin writes, M1 rd_id=2 -> next cycle rd_valid=2'b10, rd_data=0x11, bank_empty[2]=1.
- Empty read: after reset, M0 rd_id=3 -> next cycle rd_err=2'b01, rd_valid=0, rd_data=0.
- Full/skip: 16 M0 writes -> bank_full=4'hF; M0 pops bank1, then writes 0xAA with wr_bank=0.
  - Without macro: wr_drop[0] pulses, counts unchanged.
  - With macro: 0xAA lands in bank1, bank_full=4'hF, wr_bank=2.
- Wrap-around: one bank receives 6 pushes interleaved with pops -> pops return FIFO order across pointer wrap; a same-cycle push/pop leaves the count unchanged.
